// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: fair round-robin share of one registered AND/OR/XOR/ANDN unit between two requesters.
// Latency: result appears one cycle after acceptance; sustains one accepted op per cycle.
// Backpressure: while a result is held and res_ready is low, neither requester gets ready.
// Optional build macro LOGIC_ARB_STATS_EN adds saturating per-port grant counters (grant_cnt0/1).

module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             can_accept;
  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_result;

  // The output slot can take a new op if it is empty or is being drained this cycle.
  assign can_accept = (state == EMPTY) | res_ready;

  // Round-robin pick: a lone requester wins outright, a tie goes to whoever did not win last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  // Readies are forced low during reset so nothing is handshaken while state is being cleared.
  assign req0_ready = rst_n & can_accept & grant_vld & ~grant_id;
  assign req1_ready = rst_n & can_accept & grant_vld &  grant_id;
  assign accept     = req0_ready | req1_ready;

  // Steer the winning requester's operands into the shared logic unit.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (grant_id) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  // Shared bitwise unit; all four codes are decoded so no default result is ever used.
  always_comb begin
    op_result = '0;
    case (sel_op)
      OP_AND:  op_result = sel_a & sel_b;
      OP_OR:   op_result = sel_a | sel_b;
      OP_XOR:  op_result = sel_a ^ sel_b;
      OP_ANDN: op_result = sel_a & ~sel_b;
      default: op_result = '0;
    endcase
  end

  // Output slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next slot state: a new accept always fills it, otherwise a drain empties it.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = FULL;
      end
      FULL: begin
        if (accept)         state_nxt = FULL;
        else if (res_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign res_valid = (state == FULL);

  // Result payload and round-robin pointer load only on an accepted op; otherwise they hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data   <= '0;
      res_id     <= 1'b0;
      res_zero   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      res_data   <= op_result;
      res_id     <= grant_id;
      res_zero   <= ~|op_result;
      last_grant <= grant_id;
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  // Per-port accepted-op counters, saturating so a long run never wraps back to small values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && req0_valid && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && req1_valid && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed and random checks of logic_unit_arbiter against a transaction-level model.
// Model state is just "held result + who won last"; expected results come from plain bitwise arithmetic.
// Build with LOGIC_ARB_STATS_EN defined to also exercise the grant counters.

module tb_logic_unit_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [1:0]   req0_op = 2'b00;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [1:0]   req1_op = 2'b00;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_zero;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]  grant_cnt0;
  logic [15:0]  grant_cnt1;
`endif

  int n_run  = 0;
  int n_fail = 0;

  // reference model state
  logic         m_vld  = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_id   = 1'b0;
  logic         m_zero = 1'b0;
  logic         m_last = 1'b1;
  int           m_cnt0 = 0;
  int           m_cnt1 = 0;
  logic         last_acc0 = 1'b0;
  logic         last_acc1 = 1'b0;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_zero   (res_zero)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // Which requester the rules say should be ready right now (from model state and current inputs).
  function automatic logic exp_ready(input int n);
    int g;
    g = -1;
    if (req0_valid && !req1_valid)      g = 0;
    else if (!req0_valid && req1_valid) g = 1;
    else if (req0_valid && req1_valid)  g = m_last ? 0 : 1;
    return rst_n && (!m_vld || res_ready) && (g == n);
  endfunction

  // Advance one clock, applying the transaction-level rules to the model.
  task automatic step();
    logic r0, r1;
    @(posedge clk);
    r0 = exp_ready(0);
    r1 = exp_ready(1);
    last_acc0 = req0_valid && r0;
    last_acc1 = req1_valid && r1;
    if (!rst_n) begin
      m_vld = 1'b0; m_data = '0; m_id = 1'b0; m_zero = 1'b0; m_last = 1'b1;
      m_cnt0 = 0; m_cnt1 = 0;
      last_acc0 = 1'b0; last_acc1 = 1'b0;
    end else if (last_acc0 || last_acc1) begin
      m_vld  = 1'b1;
      m_id   = last_acc1;
      m_data = last_acc1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
      m_zero = (m_data == '0);
      m_last = last_acc1;
      if (last_acc0 && m_cnt0 < 65535) m_cnt0++;
      if (last_acc1 && m_cnt1 < 65535) m_cnt1++;
    end else if (m_vld && res_ready) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_run++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready: got %b%b expected 00", req1_ready, req0_ready);
      end
      step();
      n_run++;
      if (res_valid !== 1'b0 || res_data !== '0 || res_id !== 1'b0 || res_zero !== 1'b0) begin
        n_fail++; $display("FAIL reset_outputs: got vld=%b data=%h id=%b zero=%b expected 0/0000/0/0", res_valid, res_data, res_id, res_zero);
      end
    end
    rst_n = 1'b1;
    #2;
    n_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_grant: got r1r0=%b%b expected 01", req1_ready, req0_ready);
    end
  endtask

  task automatic test_and();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'hF0F0; req0_b = 16'hFF00; res_ready = 1'b1;
    #2;
    n_run++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL and_ready: got %b expected 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    #2;
    n_run++;
    if (res_valid !== 1'b1 || res_data !== 16'hF000 || res_id !== 1'b0 || res_zero !== 1'b0) begin
      n_fail++; $display("FAIL and_result: got vld=%b data=%h id=%b zero=%b expected 1/f000/0/0", res_valid, res_data, res_id, res_zero);
    end
    step();
    #2;
    n_run++;
    if (res_valid !== 1'b0 || res_data !== 16'hF000) begin
      n_fail++; $display("FAIL and_drain: got vld=%b data=%h expected 0/f000", res_valid, res_data);
    end
  endtask

  task automatic test_alternate();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h1234; req0_b = 16'h1234;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 16'h1234; req1_b = 16'h1234;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_run++;
      if (req0_ready !== logic'(i % 2 == 0) || req1_ready !== logic'(i % 2 == 1)) begin
        n_fail++; $display("FAIL alt_grant[%0d]: got r1r0=%b%b expected grant %0d", i, req1_ready, req0_ready, i % 2);
      end
      if (i > 0) begin
        n_run++;
        if (res_valid !== 1'b1 || res_zero !== 1'b1 || res_data !== '0 || res_id !== logic'((i - 1) % 2)) begin
          n_fail++; $display("FAIL alt_result[%0d]: got vld=%b zero=%b data=%h id=%b expected 1/1/0000/%0d", i, res_valid, res_zero, res_data, res_id, (i - 1) % 2);
        end
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2;
    n_run++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res_zero !== 1'b1) begin
      n_fail++; $display("FAIL alt_last: got vld=%b id=%b zero=%b expected 1/1/1", res_valid, res_id, res_zero);
    end
    step();
  endtask

  task automatic test_backpressure();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'h00FF; req0_b = 16'h0F00; res_ready = 1'b1;
    step();
    req0_valid = 1'b0; res_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 16'hABCD; req1_b = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_run++;
      if (req1_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 16'h0FFF || res_id !== 1'b0 || res_zero !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b data=%h id=%b zero=%b expected 0/1/0fff/0/0", i, req1_ready, res_valid, res_data, res_id, res_zero);
      end
      step();
    end
    res_ready = 1'b1;
    #2;
    n_run++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    #2;
    n_run++;
    if (res_valid !== 1'b1 || res_data !== 16'hAB00 || res_id !== 1'b1 || res_zero !== 1'b0) begin
      n_fail++; $display("FAIL bp_result: got vld=%b data=%h id=%b zero=%b expected 1/ab00/1/0", res_valid, res_data, res_id, res_zero);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'hFFFF; req0_b = 16'h1111; res_ready = 1'b1;
    step();
    res_ready = 1'b0; req0_a = 16'h2222;
    step();
    rst_n = 1'b0;
    step();
    #2;
    n_run++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got vld=%b data=%h id=%b expected 0/0000/0", res_valid, res_data, res_id);
    end
    rst_n = 1'b1; req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 16'h0101; req1_b = 16'h1010; res_ready = 1'b1;
    #2;
    n_run++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_grant1: got r1r0=%b%b expected 10", req1_ready, req0_ready);
    end
    step();
    req1_valid = 1'b0;
    #2;
    n_run++;
    if (res_valid !== 1'b1 || res_data !== 16'h1111 || res_id !== 1'b1) begin
      n_fail++; $display("FAIL midreset_result: got vld=%b data=%h id=%b expected 1/1111/1", res_valid, res_data, res_id);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid || last_acc0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_op = 2'($urandom);
        req0_a  = 16'($urandom);
        req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : 16'($urandom);
      end
      if (!req1_valid || last_acc1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_op = 2'($urandom);
        req1_a  = 16'($urandom);
        req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : 16'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      #2;
      n_run++;
      if (req0_ready !== exp_ready(0) || req1_ready !== exp_ready(1)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got r1r0=%b%b expected %b%b", i, req1_ready, req0_ready, exp_ready(1), exp_ready(0));
      end
      n_run++;
      if (res_valid !== m_vld || res_data !== m_data || res_id !== m_id || res_zero !== m_zero) begin
        n_fail++; $display("FAIL rand_result[%0d]: got vld=%b data=%h id=%b zero=%b expected %b/%h/%b/%b",
                           i, res_valid, res_data, res_id, res_zero, m_vld, m_data, m_id, m_zero);
      end
      step();
    end
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    step();
  endtask

`ifdef LOGIC_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    #2;
    n_run++;
    if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
      n_fail++; $display("FAIL stats_reset: got %h/%h expected 0000/0000", grant_cnt0, grant_cnt1);
    end
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h5555; req0_b = 16'hFFFF; res_ready = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    req0_valid = 1'b0;
    #2;
    n_run++;
    if (grant_cnt0 !== 16'hFFFF || grant_cnt1 !== 16'h0 || int'(grant_cnt0) != m_cnt0) begin
      n_fail++; $display("FAIL stats_saturate: got %h/%h expected ffff/0000", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_and();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef LOGIC_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
